// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
//
// Optional feature macro: BCD_BLANK_EN (adds the leading-zero blank output).
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   reset    - synchronous active-high reset
//   start    - one-cycle request to convert bin_in, honoured only when idle
//   bin_in   - unsigned binary value [BITS-1:0], sampled on the accepting edge
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse, bcd_out/overflow valid from this cycle on
//   bcd_out  - packed BCD [4*DIGITS-1:0], digit 0 in bits [3:0]
//   overflow - bin_in did not fit in DIGITS decimal digits
//   blank    - (BCD_BLANK_EN only) [DIGITS-1:0], blank[i] set when digit i and
//              all higher digits are zero (i >= 1); blank[0] is always 0

module bin_to_bcd_seq #(
    parameter int BITS   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BITS-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, DONE} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [BITS-1:0]     sr;
    logic [CW-1:0]       cnt;
    logic                sticky;

    // Digits >= 5 get +3 so the following doubling carries correctly into
    // the next decimal digit.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;

    // Scan from the most significant digit down; a digit is blank only while
    // every digit above it is also zero. Digit 0 is never blanked.
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        blank_next = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (acc[4*i +: 4] == 4'd0);
            blank_next[i] = all_zero;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            acc      <= '0;
            sr       <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
`ifdef BCD_BLANK_EN
            blank    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr     <= bin_in;
                        acc    <= '0;
                        cnt    <= CW'(BITS);
                        sticky <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ADJUST;
                    end
                end
                ADJUST: begin
                    acc   <= acc_adj;
                    state <= SHIFT;
                end
                SHIFT: begin
                    // A 1 leaving the top digit means the value has reached
                    // 10^DIGITS; the accumulator keeps the value modulo that.
                    {acc, sr} <= {acc[4*DIGITS-2:0], sr, 1'b0};
                    sticky    <= sticky | acc[4*DIGITS-1];
                    cnt       <= cnt - CW'(1);
                    state     <= (cnt == CW'(1)) ? DONE : ADJUST;
                end
                DONE: begin
                    bcd_out  <= acc;
                    overflow <= sticky;
                    done     <= 1'b1;
                    busy     <= 1'b0;
`ifdef BCD_BLANK_EN
                    blank    <= blank_next;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq

module tb_bin_to_bcd_seq;

    localparam int LAT = 2 * 16 + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [19:0] bcd_out;
`ifdef BCD_BLANK_EN
    logic [4:0]  blank;
    logic [3:0]  blank4;
`endif

    logic        start4 = 1'b0;
    logic [15:0] bin4 = '0;
    logic        busy4, done4, overflow4;
    logic [15:0] bcd4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BITS(16), .DIGITS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
`ifdef BCD_BLANK_EN
        , .blank(blank)
`endif
    );

    bin_to_bcd_seq #(.BITS(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(overflow4)
`ifdef BCD_BLANK_EN
        , .blank(blank4)
`endif
    );

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [19:0] model_bcd(input int v, input int d);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int v);
        logic [4:0] r;
        int m;
        r = '0;
        m = v % 100000;
        for (int i = 1; i < 5; i++) r[i] = (m < pow10(i));
        return r;
    endfunction

    // Drives start for one edge, then counts edges until done (bounded).
    task automatic do_conv(input logic [15:0] v, output int lat, output int busy_cycles);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 16'($urandom);
        busy_cycles = busy ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic do_conv4(input logic [15:0] v, output int lat);
        start4 = 1'b1;
        bin4   = v;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        bin4   = 16'($urandom);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, overflow, bcd_out} !== 23'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy, done, overflow, bcd_out);
        else pass_cnt++;
        total_cnt++;
        if ({busy4, done4, overflow4, bcd4} !== 19'd0)
            $display("FAIL reset_outputs4: got busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy4, done4, overflow4, bcd4);
        else pass_cnt++;
`ifdef BCD_BLANK_EN
        total_cnt++;
        if (blank !== 5'd0) $display("FAIL reset_blank: got %b want 00000", blank);
        else pass_cnt++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_max;
        int lat, bc;
        do_conv(16'd65535, lat, bc);
        total_cnt++;
        if (lat !== LAT) $display("FAIL max_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (bcd_out !== 20'h65535 || overflow !== 1'b0)
            $display("FAIL max_result: got bcd=%h ovf=%b want 65535 ovf=0", bcd_out, overflow);
        else pass_cnt++;
        total_cnt++;
        if (bc !== LAT) $display("FAIL max_busy_cycles: got %0d want %0d", bc, LAT);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL max_busy_clear: got %b want 0", busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bcd_out !== 20'h65535) $display("FAIL hold_result: got %h want 65535", bcd_out);
        else pass_cnt++;
    endtask

    task automatic test_zero;
        int lat, bc;
        do_conv(16'd0, lat, bc);
        total_cnt++;
        if (lat !== LAT || bcd_out !== 20'h0 || overflow !== 1'b0)
            $display("FAIL zero: got lat=%0d bcd=%h ovf=%b want lat=%0d bcd=00000 ovf=0",
                     lat, bcd_out, overflow, LAT);
        else pass_cnt++;
`ifdef BCD_BLANK_EN
        total_cnt++;
        if (blank !== 5'b11110) $display("FAIL zero_blank: got %b want 11110", blank);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random;
        int lat, bc, v;
        for (int k = 0; k < 20; k++) begin
            v = (k == 0) ? 9999 : (k == 1) ? 10000 : int'($urandom_range(0, 65535));
            do_conv(16'(v), lat, bc);
            total_cnt++;
            if (lat !== LAT || bcd_out !== model_bcd(v, 5) || overflow !== 1'b0)
                $display("FAIL random_%0d: in=%0d got lat=%0d bcd=%h ovf=%b want lat=%0d bcd=%h ovf=0",
                         k, v, lat, bcd_out, overflow, LAT, model_bcd(v, 5));
            else pass_cnt++;
`ifdef BCD_BLANK_EN
            total_cnt++;
            if (blank !== model_blank(v))
                $display("FAIL random_blank_%0d: got %b want %b", k, blank, model_blank(v));
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_digits4;
        int lat, v;
        logic [15:0] exp;
        for (int k = 0; k < 12; k++) begin
            v = (k == 0) ? 12345 : (k == 1) ? 9999 : (k == 2) ? 10000 : int'($urandom_range(0, 65535));
            do_conv4(16'(v), lat);
            exp = 16'(model_bcd(v % 10000, 4));
            total_cnt++;
            if (lat !== LAT || bcd4 !== exp || overflow4 !== (v >= 10000))
                $display("FAIL digits4_%0d: in=%0d got lat=%0d bcd=%h ovf=%b want lat=%0d bcd=%h ovf=%b",
                         k, v, lat, bcd4, overflow4, LAT, exp, (v >= 10000));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic saw_done;
        saw_done = 1'b0;
        start  = 1'b1;
        bin_in = 16'd1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        start = 1'b1;
        bin_in = 16'd555;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, overflow, bcd_out} !== 23'd0 || saw_done)
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h early_done=%b want all 0",
                     busy, done, overflow, bcd_out, saw_done);
        else pass_cnt++;
        reset = 1'b0;
        do_conv(16'd42, lat, bc);
        total_cnt++;
        if (lat !== LAT || bcd_out !== 20'h00042 || overflow !== 1'b0)
            $display("FAIL after_reset: got lat=%0d bcd=%h ovf=%b want lat=%0d bcd=00042 ovf=0",
                     lat, bcd_out, overflow, LAT);
        else pass_cnt++;
`ifdef BCD_BLANK_EN
        total_cnt++;
        if (blank !== 5'b11100) $display("FAIL after_reset_blank: got %b want 11100", blank);
        else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        lat = 0;
        start  = 1'b1;
        bin_in = 16'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (n == 5) begin
                start  = 1'b1;
                bin_in = 16'd999;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        total_cnt++;
        if (lat !== LAT || bcd_out !== 20'h00100)
            $display("FAIL b2b_first: got lat=%0d bcd=%h want lat=%0d bcd=00100", lat, bcd_out, LAT);
        else pass_cnt++;
        do_conv(16'd7, lat, bc);
        total_cnt++;
        if (lat !== LAT || bcd_out !== 20'h00007)
            $display("FAIL b2b_second: got lat=%0d bcd=%h want lat=%0d bcd=00007", lat, bcd_out, LAT);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero();
        test_random();
        test_digits4();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter BITS, default 16, width of the binary input (matches the divider's quotient/remainder width).
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to convert bin_in (normally driven by the divider's done).
REQ-006 SHALL have port bin_in, input, BITS, the unsigned binary value, sampled only on the edge that accepts start.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse marking that the result is valid.
REQ-009 SHALL have port bcd_out, output, 4*DIGITS, packed BCD with digit 0 in bits [3:0].
REQ-010 SHALL have port overflow, output, 1, high when bin_in >= 10^DIGITS.

Function
REQ-011 SHALL implement sequential double-dabble using states IDLE, ADJUST, SHIFT and DONE.
REQ-012 IDLE: with start=1, SHALL load bin_in into a shift register, clear the BCD accumulator, set the bit counter to BITS, set busy=1 and go to ADJUST.
REQ-013 ADJUST: SHALL add 3 to each 4-bit accumulator digit >= 5, then go to SHIFT.
REQ-014 SHIFT: SHALL left-shift {accumulator, shift register} by 1 and decrement the counter; go to DONE if the counter reaches 0, else go to ADJUST.
REQ-015 SHALL set an internal sticky overflow when any 1 is shifted out of the top accumulator digit during SHIFT.
REQ-016 DONE: SHALL, on the same edge, load bcd_out from the accumulator, load overflow from the sticky flag, set done=1, clear busy and return to IDLE.
REQ-017 done SHALL be registered, high for exactly one cycle, and driven to 0 in every cycle other than the one following the DONE edge.
REQ-018 Latency: done and bcd_out SHALL update on rising edge 2*BITS+1 after the edge that accepts start (33 edges for BITS=16).
REQ-019 On overflow, bcd_out SHALL hold the low DIGITS decimal digits of bin_in (value modulo 10^DIGITS).
REQ-020 start SHALL be ignored in every state other than IDLE, so bin_in changes during busy have no effect.
REQ-021 start asserted in the cycle where done is high SHALL be accepted, because the state is already IDLE; back-to-back conversions are supported.
REQ-022 bcd_out and overflow SHALL hold their values between done pulses.
REQ-023 bin_in=0 SHALL produce bcd_out=0 and overflow=0 with the normal latency.

Reset
REQ-024 When reset=1 at a rising edge: state SHALL become IDLE, and busy, done, overflow and bcd_out SHALL all become 0; the internal accumulator, counter and sticky overflow SHALL be cleared.
REQ-025 Reset mid-conversion SHALL abort the conversion with no done pulse; a start on the first edge after reset is released SHALL be accepted.
REQ-026 Reset SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro BCD_BLANK_EN defined: SHALL add output port blank, width DIGITS, registered and updated with bcd_out.
REQ-028 Under BCD_BLANK_EN, blank[i] SHALL be 1 when digit i and all higher digits are zero, for i >= 1; blank[0] SHALL always be 0; reset value SHALL be 0.
REQ-029 Macro BCD_BLANK_EN undefined: the blank port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset, then start with bin_in=16'd65535 (BITS=16, DIGITS=5) -> done on the 33rd edge after start, bcd_out=20'h65535, overflow=0, busy high for 33 cycles.
REQ-031 bin_in=0 -> bcd_out=20'h00000, overflow=0; with BCD_BLANK_EN, blank=5'b11110.
REQ-032 DIGITS=4, bin_in=12345 -> overflow=1, bcd_out=16'h2345.
REQ-033 Start with 1234, assert reset at edge 10 -> no done, all outputs 0; then start with 42 -> bcd_out=20'h00042; with BCD_BLANK_EN, blank=5'b11100.
REQ-034 Start with 100, pulse start with 999 at edge 5 (ignored), then start with 7 in the done cycle -> first result 20'h00100, second result 20'h00007 exactly 33 edges later.
